// File: rtl/tx_port_event_writer_256.sv
`default_nettype none
// ============================================================================
// Module      : tx_port_event_writer_256
// Description : Turns a user TX transaction (open / payload / close) into a
//               stream of 257-bit words for an event FIFO. Bit 256 tags the
//               word as an event (1) or payload (0). Two open events carry
//               the latched LEN/OFF/LAST, payload beats follow, and two close
//               events carry the final 32-bit word count.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_port_event_writer_256 #(
    // Payload width in bits; the event word layout assumes 256.
    parameter int C_DATA_WIDTH = 256
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CHNL_TX,
    output logic                    CHNL_TX_ACK,
    input  logic                    CHNL_TX_LAST,
    input  logic [31:0]             CHNL_TX_LEN,
    input  logic [30:0]             CHNL_TX_OFF,
    input  logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                    CHNL_TX_DATA_VALID,
    output logic                    CHNL_TX_DATA_REN,
    output logic [C_DATA_WIDTH:0]   EVT_DATA,
    output logic                    EVT_DATA_WR_EN,
    input  logic                    EVT_DATA_AFULL
);

    // ------------------------------------------------------------------
    // One-hot state encoding
    // ------------------------------------------------------------------
    localparam logic [6:0] c_S_IDLE    = 7'b000_0001;
    localparam logic [6:0] c_S_OPEN_0  = 7'b000_0010;
    localparam logic [6:0] c_S_OPEN_1  = 7'b000_0100;
    localparam logic [6:0] c_S_ACK     = 7'b000_1000;
    localparam logic [6:0] c_S_DATA    = 7'b001_0000;
    localparam logic [6:0] c_S_CLOSE_0 = 7'b010_0000;
    localparam logic [6:0] c_S_CLOSE_1 = 7'b100_0000;

    // Words advanced per accepted 256-bit beat (32-bit words).
    localparam logic [31:0] c_WORDS_PER_BEAT = 32'd8;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [6:0]              r_state;
    logic [31:0]             r_len;
    logic [30:0]             r_off;
    logic                    r_last;
    logic [31:0]             r_count;
    logic [C_DATA_WIDTH:0]   r_evt_data;
    logic                    r_evt_wr_en;

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    logic [6:0]              w_state_nxt;
    logic                    w_capture;
    logic                    w_ack;
    logic                    w_ren;
    logic                    w_beat;
    logic                    w_cnt_clr;
    logic                    w_wr;
    logic [C_DATA_WIDTH:0]   w_wdata;
    logic [C_DATA_WIDTH:0]   w_open_word;
    logic [C_DATA_WIDTH:0]   w_close_word;
    logic                    w_room;

    // Event word images built from the latched parameters / live counter.
    assign w_open_word  = {1'b1, {(C_DATA_WIDTH-64){1'b0}}, r_len, r_off, r_last};
    assign w_close_word = {1'b1, {(C_DATA_WIDTH-32){1'b0}}, r_count};

    // The FIFO may take a word this cycle only while it is not almost full.
    assign w_room = ~EVT_DATA_AFULL;

    // State register: asynchronous reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (CHNL_TX) begin
                    w_state_nxt = c_S_OPEN_0;
                end
            end
            c_S_OPEN_0: begin
                if (w_room) begin
                    w_state_nxt = c_S_OPEN_1;
                end
            end
            c_S_OPEN_1: begin
                if (w_room) begin
                    w_state_nxt = c_S_ACK;
                end
            end
            c_S_ACK: begin
                // Always a single cycle, even if CHNL_TX has already dropped.
                w_state_nxt = c_S_DATA;
            end
            c_S_DATA: begin
                if (!CHNL_TX) begin
                    w_state_nxt = c_S_CLOSE_0;
                end
            end
            c_S_CLOSE_0: begin
                if (w_room) begin
                    w_state_nxt = c_S_CLOSE_1;
                end
            end
            c_S_CLOSE_1: begin
                if (w_room) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                // Any non-one-hot value recovers to IDLE.
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Output / write-decision logic for the current state.
    always_comb begin
        w_capture = 1'b0;
        w_ack     = 1'b0;
        w_ren     = 1'b0;
        w_cnt_clr = 1'b0;
        w_wr      = 1'b0;
        w_wdata   = '0;
        case (r_state)
            c_S_IDLE: begin
                w_capture = CHNL_TX;
            end
            c_S_OPEN_0, c_S_OPEN_1: begin
                w_wr    = w_room;
                w_wdata = w_open_word;
            end
            c_S_ACK: begin
                w_ack     = 1'b1;
                w_cnt_clr = 1'b1;
            end
            c_S_DATA: begin
                // Stop reading once the requested length has been covered;
                // with LEN = 0 this is never true.
                w_ren   = w_room & (r_count < r_len);
                w_wr    = w_ren & CHNL_TX_DATA_VALID;
                w_wdata = {1'b0, CHNL_TX_DATA};
            end
            c_S_CLOSE_0, c_S_CLOSE_1: begin
                w_wr    = w_room;
                w_wdata = w_close_word;
            end
            default: begin
                w_wr = 1'b0;
            end
        endcase
    end

    // A beat is consumed only on the REN/VALID handshake.
    assign w_beat = w_ren & CHNL_TX_DATA_VALID;

    // Transaction parameters are sampled once per transaction, in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_len  <= '0;
            r_off  <= '0;
            r_last <= 1'b0;
        end else if (w_capture) begin
            r_len  <= CHNL_TX_LEN;
            r_off  <= CHNL_TX_OFF;
            r_last <= CHNL_TX_LAST;
        end
    end

    // Word counter: cleared on ACK, advanced by one beat's worth of words.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (w_cnt_clr) begin
            r_count <= '0;
        end else if (w_beat) begin
            r_count <= r_count + c_WORDS_PER_BEAT;
        end
    end

    // FIFO write port is registered: strobe appears one cycle after the decision.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_evt_wr_en <= 1'b0;
            r_evt_data  <= '0;
        end else begin
            r_evt_wr_en <= w_wr;
            if (w_wr) begin
                r_evt_data <= w_wdata;
            end
        end
    end

    assign CHNL_TX_ACK      = w_ack;
    assign CHNL_TX_DATA_REN = w_ren;
    assign EVT_DATA         = r_evt_data;
    assign EVT_DATA_WR_EN   = r_evt_wr_en;

endmodule
`default_nettype wire

// File: doc/tx_port_event_writer_256.md
TX_PORT_EVENT_WRITER_256 -- requirements
Module: tx_port_event_writer_256

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 256, meaning the payload width in bits; only 256 is supported.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port CHNL_TX, input, 1 bit: user holds it high for the duration of a transaction.
REQ-005 SHALL have port CHNL_TX_ACK, output, 1 bit: one-cycle pulse meaning the transaction parameters were captured.
REQ-006 SHALL have port CHNL_TX_LAST, input, 1 bit: last-write flag.
REQ-007 SHALL have port CHNL_TX_LEN, input, 32 bits: transaction length in 32-bit words.
REQ-008 SHALL have port CHNL_TX_OFF, input, 31 bits: write offset.
REQ-009 SHALL have port CHNL_TX_DATA, input, C_DATA_WIDTH bits: user payload.
REQ-010 SHALL have port CHNL_TX_DATA_VALID, input, 1 bit: CHNL_TX_DATA is valid.
REQ-011 SHALL have port CHNL_TX_DATA_REN, output, 1 bit: a beat is taken when REN and VALID are both high.
REQ-012 SHALL have port EVT_DATA, output, C_DATA_WIDTH+1 bits: bit C_DATA_WIDTH set marks an event word, clear marks payload.
REQ-013 SHALL have port EVT_DATA_WR_EN, output, 1 bit: write strobe into the event FIFO.
REQ-014 SHALL have port EVT_DATA_AFULL, input, 1 bit: the FIFO can accept at most one more word.

Function
REQ-015 SHALL use the FSM states IDLE, OPEN_0, OPEN_1, ACK, DATA, CLOSE_0 and CLOSE_1, one-hot encoded.
REQ-016 In IDLE with CHNL_TX high, SHALL latch LAST, OFF and LEN into parameter registers and go to OPEN_0.
REQ-017 In OPEN_0 and OPEN_1 with EVT_DATA_AFULL low, SHALL write one open event each and advance.
  - Open event: bit 256 = 1; [63:32] = LEN; [31:1] = OFF; [0] = LAST; all other bits 0.
  - OPEN_0 advances to OPEN_1; OPEN_1 advances to ACK.
  - With AFULL high, SHALL hold the state and write nothing.
REQ-018 In ACK, SHALL assert CHNL_TX_ACK for exactly one cycle, clear the word counter, and go to DATA.
REQ-019 In DATA, SHALL drive CHNL_TX_DATA_REN = !EVT_DATA_AFULL & (count < LEN), where LEN is the latched value.
REQ-020 On each accepted beat, SHALL write {1'b0, CHNL_TX_DATA} and add 8 to the 32-bit word counter (modulo 2^32).
REQ-021 In DATA, SHALL go to CLOSE_0 when CHNL_TX is low; a beat accepted in that same cycle is still written.
REQ-022 With latched LEN = 0, SHALL hold CHNL_TX_DATA_REN low throughout DATA.
REQ-023 Data offered after count >= LEN SHALL not be accepted; CHNL_TX_DATA_REN stays low until CLOSE.
REQ-024 In CLOSE_0 and CLOSE_1 with EVT_DATA_AFULL low, SHALL write one close event each.
  - Close event: bit 256 = 1; [31:0] = word counter; all other bits 0.
  - CLOSE_0 advances to CLOSE_1; CLOSE_1 advances to IDLE.
REQ-025 SHALL register EVT_DATA and EVT_DATA_WR_EN, giving a fixed latency of 1 cycle from the write decision to the strobe.
REQ-026 SHALL produce at most one EVT_DATA_WR_EN per cycle.
REQ-027 SHALL never write while EVT_DATA_AFULL was high in the decision cycle.
REQ-028 SHALL complete OPEN_0 through ACK even if CHNL_TX falls before ACK.
  - ACK is still pulsed; DATA then exits to CLOSE_0 on the next cycle.
REQ-029 SHALL not start a new transaction until IDLE is re-entered; CHNL_TX held high after CLOSE_1 starts the next transaction from IDLE.
REQ-030 CHNL_TX_LEN, OFF and LAST changes after latching SHALL have no effect until the next IDLE capture.

Reset
REQ-031 On RST low, SHALL asynchronously reset the following:
  - state to IDLE;
  - CHNL_TX_ACK, CHNL_TX_DATA_REN and EVT_DATA_WR_EN to 0;
  - EVT_DATA to 0;
  - word counter and parameter registers to 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it without writing close events.
  - After RST rises, the first write SHALL be an open event.
REQ-033 SHALL leave the reset state on the first rising CLK edge after RST deasserts.

Verification
REQ-034 LEN=16, OFF=5, LAST=1, two valid beats, CHNL_TX then low -> expected FIFO sequence:
  - two events with [63:0] = 0x0000_0010_0000_000B;
  - two payload words;
  - two close events with [31:0] = 16;
  - exactly one ACK pulse.
REQ-035 LEN=0 -> expected response:
  - two open events, then ACK;
  - REN never asserted;
  - two close events with count 0 after CHNL_TX falls.
REQ-036 AFULL held high during OPEN_1 for 5 cycles -> expected response:
  - no write during those cycles;
  - the second open event appears 1 cycle after AFULL falls;
  - ACK follows on the next cycle.
REQ-037 LEN=8 with 3 beats offered -> expected response:
  - only the first beat is accepted;
  - REN is 0 thereafter;
  - close events carry [31:0] = 8.
REQ-038 RST low during DATA after 1 beat -> expected response:
  - outputs are 0 immediately;
  - the next transaction begins with an open event and its count restarts at 0.
